input_conditioner: RTL and testbench

- Parametrised successor to the fixed four-input synchronizer.
- Brings NUM_CH asynchronous inputs (global reset request, traffic sensor, walk request, reprogram) into the clk domain through a configurable-depth flop chain.
- Debounces each channel with a per-channel counter and produces a clean level plus single-cycle rise and fall pulses.
- Sits between the pad inputs and the traffic FSM / timer blocks.

---
 rtl/input_cond_pkg.sv | 29 ++
 rtl/input_cond_channel.sv | 108 ++++++++++
 rtl/input_conditioner.sv | 54 +++++
 tb/tb_input_conditioner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// ---------------------------------------------------------------------------
// input_cond_pkg
// Shared constants for the input conditioner slice.
//   - Channel index constants naming what each async_in bit carries.
//   - Default channel count, synchronizer depth and debounce length.
//   - calc_cnt_w(): width of the per-channel debounce counter.
// Optional feature macro used by the design files: INPUT_CONDITIONER_LATCH_EN
// ---------------------------------------------------------------------------
package input_cond_pkg;

    // Which pad lands on which bit of async_in.
    localparam int CH_RESET   = 0;
    localparam int CH_TRAFFIC = 1;
    localparam int CH_WALK    = 2;
    localparam int CH_REPROG  = 3;

    localparam int DEF_NUM_CH          = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    // A debounce length of 1 still needs a 1-bit counter so the
    // compare logic stays well formed.
    function automatic int calc_cnt_w(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_cond_channel.sv
// ---------------------------------------------------------------------------
// input_cond_channel
// One conditioned input: synchronizer chain, debounce counter, clean level
// and registered single-cycle rise/fall pulses.
// Ports:
//   clk           system clock, all state on the rising edge
//   global_reset  synchronous active-low reset
//   async_in      raw asynchronous input bit
//   level         debounced, synchronized level
//   rise / fall   one-cycle pulses coinciding with the first new-level cycle
//   latch_clr     (INPUT_CONDITIONER_LATCH_EN only) clears latched
//   latched       (INPUT_CONDITIONER_LATCH_EN only) sticky copy of rise
// ---------------------------------------------------------------------------
module input_cond_channel
    import input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic global_reset,
    input  logic async_in,
`ifdef INPUT_CONDITIONER_LATCH_EN
    input  logic latch_clr,
    output logic latched,
`endif
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = calc_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift the raw input through the chain, then debounce the chain output.
    // The counter only runs while the synced value disagrees with the level;
    // any agreement throws away the partial count, which is what rejects
    // glitches shorter than DEBOUNCE_CYCLES.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            level_d = synced;
            cnt_d   = '0;
            rise_d  = synced;
            fall_d  = ~synced;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!global_reset) begin
            sync_q  <= {SYNC_STAGES{RESET_VALUE}};
            cnt_q   <= '0;
            level_q <= RESET_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

`ifdef INPUT_CONDITIONER_LATCH_EN
    logic latched_q, latched_d;

    // Set has priority over clear so a request arriving in the same cycle
    // the consumer acknowledges the previous one is not lost.
    always_comb begin
        latched_d = rise_q | (latched_q & ~latch_clr);
    end

    always_ff @(posedge clk) begin
        if (!global_reset) begin
            latched_q <= 1'b0;
        end else begin
            latched_q <= latched_d;
        end
    end

    assign latched = latched_q;
`endif

endmodule

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
// Brings NUM_CH asynchronous pad inputs into the clk domain, debounces each
// one independently and produces clean levels plus rise/fall pulses.
// Ports:
//   clk           system clock
//   global_reset  synchronous active-low reset from an upstream synchronizer
//   async_in      raw asynchronous inputs (bit order per input_cond_pkg CH_*)
//   level         debounced levels
//   rise / fall   single-cycle edge pulses per channel
//   latch_clr     (INPUT_CONDITIONER_LATCH_EN only) per-channel latch clear
//   latched       (INPUT_CONDITIONER_LATCH_EN only) per-channel sticky rise
// ---------------------------------------------------------------------------
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int                NUM_CH          = DEF_NUM_CH,
    parameter int                SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [NUM_CH-1:0] RESET_VALUE     = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              global_reset,
    input  logic [NUM_CH-1:0] async_in,
`ifdef INPUT_CONDITIONER_LATCH_EN
    input  logic [NUM_CH-1:0] latch_clr,
    output logic [NUM_CH-1:0] latched,
`endif
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall
);

    // Channels share nothing but clock and reset.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        input_cond_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[ch])
        ) u_channel (
            .clk          (clk),
            .global_reset (global_reset),
            .async_in     (async_in[ch]),
`ifdef INPUT_CONDITIONER_LATCH_EN
            .latch_clr    (latch_clr[ch]),
            .latched      (latched[ch]),
`endif
            .level        (level[ch]),
            .rise         (rise[ch]),
            .fall         (fall[ch])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
// Self-checking bench for input_conditioner with default parameters.
// A reference model derived from the debounce rules (delay line + "last
// DEBOUNCE_CYCLES synced samples all disagree with the level") is checked
// against the DUT every cycle, alongside directed literal expectations.
// Honours INPUT_CONDITIONER_LATCH_EN for the optional latch ports.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int              NUM_CH = 4;
    localparam int              SYNC   = 2;
    localparam int              DEB    = 4;
    localparam logic [NUM_CH-1:0] RV   = '0;

    logic              clk;
    logic              global_reset;
    logic [NUM_CH-1:0] async_in;
    logic [NUM_CH-1:0] level, rise, fall;
`ifdef INPUT_CONDITIONER_LATCH_EN
    logic [NUM_CH-1:0] latch_clr;
    logic [NUM_CH-1:0] latched;
`endif

    int vectors     = 0;
    int miscompares = 0;

    input_conditioner #(
        .NUM_CH          (NUM_CH),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .RESET_VALUE     (RV)
    ) dut (
        .clk          (clk),
        .global_reset (global_reset),
        .async_in     (async_in),
`ifdef INPUT_CONDITIONER_LATCH_EN
        .latch_clr    (latch_clr),
        .latched      (latched),
`endif
        .level        (level),
        .rise         (rise),
        .fall         (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [NUM_CH-1:0] act,
                               input logic [NUM_CH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs at the current negedge and let `cycles` clock edges pass.
    task automatic applyStimulus(input logic [NUM_CH-1:0] in, input logic rst, input int cycles);
        async_in     = in;
        global_reset = rst;
        repeat (cycles) @(negedge clk);
    endtask

    // -----------------------------------------------------------------------
    // Reference model: the synced value is async_in delayed by SYNC edges
    // (reset fills the delay with RV). A channel's level flips at an edge when
    // the DEB most recent synced samples since reset all differ from it.
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] m_pipe [SYNC];
    logic [NUM_CH-1:0] m_hist [$];
    logic [NUM_CH-1:0] m_level, m_rise, m_fall, m_latched;
    bit                model_valid = 0;

    always @(posedge clk) begin : model
        logic [NUM_CH-1:0] s;
        logic [NUM_CH-1:0] new_latched;
        bit                all_diff;
        if (!global_reset) begin
            for (int k = 0; k < SYNC; k++) m_pipe[k] = RV;
            m_hist.delete();
            m_level   = RV;
            m_rise    = '0;
            m_fall    = '0;
            m_latched = '0;
            model_valid = 1;
        end else begin
            s = m_pipe[SYNC-1];
            for (int k = SYNC-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = async_in;
            m_hist.push_back(s);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
`ifdef INPUT_CONDITIONER_LATCH_EN
            new_latched = m_rise | (m_latched & ~latch_clr);
`else
            new_latched = '0;
`endif
            m_latched = new_latched;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                all_diff = (m_hist.size() == DEB);
                for (int i = 0; i < m_hist.size(); i++)
                    if (m_hist[i][c] == m_level[c]) all_diff = 0;
                if (all_diff) begin
                    m_level[c] = s[c];
                    m_rise[c]  = s[c];
                    m_fall[c]  = ~s[c];
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("model_level", level, m_level);
            checkOutput("model_rise",  rise,  m_rise);
            checkOutput("model_fall",  fall,  m_fall);
`ifdef INPUT_CONDITIONER_LATCH_EN
            checkOutput("model_latched", latched, m_latched);
`endif
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        logic [NUM_CH-1:0] cur, nxt;
        int                rate;
        async_in     = '0;
        global_reset = 1'b0;
`ifdef INPUT_CONDITIONER_LATCH_EN
        latch_clr    = '0;
`endif
        @(negedge clk);

        // Reset with all inputs high, then release while they stay high.
        applyStimulus(4'b1111, 1'b0, 3);
        checkOutput("rst_level", level, 4'b0000);
        checkOutput("rst_rise",  rise,  4'b0000);
        checkOutput("rst_fall",  fall,  4'b0000);
        applyStimulus(4'b1111, 1'b1, 5);
        checkOutput("rel_e5_level", level, 4'b0000);
        applyStimulus(4'b1111, 1'b1, 1);
        checkOutput("rel_e6_level", level, 4'b1111);
        checkOutput("rel_e6_rise",  rise,  4'b1111);
        applyStimulus(4'b1111, 1'b1, 1);
        checkOutput("rel_e7_rise",  rise,  4'b0000);

        // Clean start, then a 3-cycle glitch on channel 2.
        applyStimulus(4'b0000, 1'b0, 2);
        applyStimulus(4'b0000, 1'b1, 3);
        applyStimulus(4'b0100, 1'b1, 3);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b0000, 1'b1, 1);
            checkOutput("glitch_level", level, 4'b0000);
            checkOutput("glitch_rise",  rise,  4'b0000);
        end

        // Clean press and release on channel 1.
        applyStimulus(4'b0010, 1'b1, 5);
        checkOutput("press_e5_level", level, 4'b0000);
        applyStimulus(4'b0010, 1'b1, 1);
        checkOutput("press_e6_level", level, 4'b0010);
        checkOutput("press_e6_rise",  rise,  4'b0010);
        applyStimulus(4'b0010, 1'b1, 4);
        applyStimulus(4'b0000, 1'b1, 5);
        checkOutput("release_e5_fall", fall, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 1);
        checkOutput("release_e6_fall",  fall,  4'b0010);
        checkOutput("release_e6_level", level, 4'b0000);

        // Channel 0 rises two cycles before channel 3.
        applyStimulus(4'b0001, 1'b1, 2);
        applyStimulus(4'b1001, 1'b1, 4);
        checkOutput("indep_rise0", rise, 4'b0001);
        applyStimulus(4'b1001, 1'b1, 2);
        checkOutput("indep_rise3", rise,  4'b1000);
        checkOutput("indep_level", level, 4'b1001);
        applyStimulus(4'b0000, 1'b1, 8);

        // Reset in the middle of channel 0's debounce count.
        applyStimulus(4'b0001, 1'b1, 3);
        applyStimulus(4'b0001, 1'b0, 1);
        checkOutput("midrst_rise",  rise,  4'b0000);
        checkOutput("midrst_level", level, 4'b0000);
        applyStimulus(4'b0001, 1'b1, 5);
        checkOutput("midrst_e5_level", level, 4'b0000);
        applyStimulus(4'b0001, 1'b1, 1);
        checkOutput("midrst_e6_rise",  rise,  4'b0001);
        checkOutput("midrst_e6_level", level, 4'b0001);
        applyStimulus(4'b0000, 1'b1, 8);

`ifdef INPUT_CONDITIONER_LATCH_EN
        // Rise and clear in the same cycle: set wins; clear alone then clears.
        applyStimulus(4'b0100, 1'b1, 6);
        checkOutput("latch_rise", rise, 4'b0100);
        latch_clr = 4'b0100;
        applyStimulus(4'b0100, 1'b1, 1);
        checkOutput("latch_set_wins", latched, 4'b0100);
        applyStimulus(4'b0100, 1'b1, 1);
        checkOutput("latch_cleared", latched, 4'b0000);
        latch_clr = 4'b0000;
`endif

        // Randomized traffic with varying activity and rare resets.
        cur  = async_in;
        rate = 4;
        for (int n = 0; n < 1500; n++) begin
            if (n % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rate = 1;
                    1:       rate = 6;
                    default: rate = 25;
                endcase
            end
            nxt = cur;
            if ($urandom_range(0, rate) == 0) nxt[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
            if ($urandom_range(0, rate) == 0) nxt[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
`ifdef INPUT_CONDITIONER_LATCH_EN
            latch_clr = NUM_CH'($urandom_range(0, 15) & $urandom_range(0, 15));
`endif
            applyStimulus(nxt, ($urandom_range(0, 149) != 0), 1);
            cur = nxt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
